fib_serial_ctrl: RTL

FIB_SERIAL_CTRL -- requirements
Module: fib_serial_ctrl

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_full_adder.sv | 13 +
 rtl/fib_serial_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and default sizing for the bit-serial Fibonacci controller.
// Optional overflow detection is enabled with FIB_OVERFLOW_DET_EN.
package fib_pkg;

    localparam int FIB_WIDTH = 16;
    localparam int FIB_NW    = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_UPDATE,
        S_DONE
    } fib_state_e;

endpackage

// File: rtl/fib_full_adder.sv
// Single-bit full adder used as the serial datapath of fib_serial_ctrl.
module fib_full_adder (
    output logic Cout,
    output logic S,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/fib_serial_ctrl.sv
// Bit-serial F(n) mod 2^WIDTH; one full adder, LSB first.
// Define FIB_OVERFLOW_DET_EN to enable the sticky carry-out flag.
module fib_serial_ctrl
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int NW    = FIB_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NW-1:0]    n,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    fib_state_e       state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [CW-1:0]    bitcnt;
    logic [NW-1:0]    iter;
    logic             s_bit;
    logic             c_out;
    logic             last_bit;

    assign last_bit = (bitcnt == CW'(WIDTH - 1));

    fib_full_adder u_fa (
        .Cout (c_out),
        .S    (s_bit),
        .A    (a[0]),
        .B    (b[0]),
        .Cin  (carry)
    );

    // a and b rotate right so they are intact again once all bits are added
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            a      <= '0;
            b      <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
            iter   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a      <= '0;
                        b      <= WIDTH'(1);
                        carry  <= 1'b0;
                        bitcnt <= '0;
                        ready  <= 1'b0;
                        if (n < NW'(2)) begin
                            iter   <= '0;
                            result <= WIDTH'(n);
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            iter  <= n - NW'(1);
                            busy  <= 1'b1;
                            state <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    a      <= {a[0], a[WIDTH-1:1]};
                    b      <= {b[0], b[WIDTH-1:1]};
                    sum    <= {s_bit, sum[WIDTH-1:1]};
                    carry  <= c_out;
                    bitcnt <= bitcnt + CW'(1);
                    if (last_bit)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    a      <= b;
                    b      <= sum;
                    carry  <= 1'b0;
                    bitcnt <= '0;
                    iter   <= iter - NW'(1);
                    if (iter > NW'(1)) begin
                        state <= S_ADD;
                    end else begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= sum;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIB_OVERFLOW_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (state == S_IDLE && start)
            overflow <= 1'b0;
        else if (state == S_ADD && last_bit && c_out)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
